// File: rtl/ahci_dma_wr_align.sv
// ahci_dma_wr_align: unstuffs a packed 32-bit stream into word-aligned DWORDs with 16-bit masks per PRD segment
// Ports: clk/rst_n clock and async active-low reset; start/woffs/wlen/clr segment control;
// busy/done segment status; din/din_av/din_re FWFT input; dout/dm/dout_vld/dout_re/last aligned output.
module ahci_dma_wr_align #(
  parameter int LEN_W = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             woffs,
  input  logic [LEN_W-1:0] wlen,
  input  logic             clr,
  output logic             busy,
  output logic             done,
  input  logic [31:0]      din,
  input  logic             din_av,
  output logic             din_re,
  output logic [31:0]      dout,
  output logic [1:0]       dm,
  output logic             dout_vld,
  input  logic             dout_re,
  output logic             last
);
  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;
  state_t state;
  logic [15:0] hr;
  logic hr_full;
  logic [LEN_W-1:0] rem;
  logic phase;
  logic slot, two, fire, use_hi, fin;
  logic [1:0] k, avail;
  logic [15:0] w0, w1;
  assign slot = !dout_vld || dout_re;
  assign two = !phase && rem > LEN_W'(1);
  assign k = two ? 2'd2 : 2'd1;
  // held word counts as one, a din DWORD as two
  assign avail = {din_av, hr_full};
  assign fire = state == RUN && slot && avail >= k;
  assign din_re = fire && k > {1'b0, hr_full};
  // words in stream order: held word first, then din low, then din high
  assign w0 = hr_full ? hr : din[15:0];
  assign w1 = hr_full ? din[15:0] : din[31:16];
  assign use_hi = !hr_full && two;
  assign fin = rem == LEN_W'(k);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hr <= '0;
      hr_full <= 1'b0;
      rem <= '0;
      phase <= 1'b0;
      dout <= '0;
      dm <= '0;
      dout_vld <= 1'b0;
      last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            if (wlen == '0) done <= 1'b1;
            else begin
              rem <= wlen;
              phase <= woffs;
              busy <= 1'b1;
              state <= RUN;
            end
          end else if (clr) hr_full <= 1'b0;
        RUN:
          if (fire) begin
            if (phase) begin
              dout[31:16] <= w0;
              dm <= 2'b10;
            end else if (two) begin
              dout <= {w1, w0};
              dm <= 2'b11;
            end else begin
              dout[15:0] <= w0;
              dm <= 2'b01;
            end
            // a consumed din whose upper word was not placed leaves that word held
            hr_full <= din_re && !use_hi;
            if (din_re && !use_hi) hr <= din[31:16];
            rem <= rem - LEN_W'(k);
            phase <= 1'b0;
            dout_vld <= 1'b1;
            last <= fin;
            state <= fin ? TAIL : RUN;
          end else if (dout_re) begin
            dout_vld <= 1'b0;
            last <= 1'b0;
          end
        TAIL:
          if (dout_vld && dout_re) begin
            dout_vld <= 1'b0;
            last <= 1'b0;
            if (last) begin
              done <= 1'b1;
              busy <= 1'b0;
              state <= IDLE;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahci_dma_wr_align.sv
// tb_ahci_dma_wr_align: scoreboard bench for the DMA write aligner
module tb_ahci_dma_wr_align;
  logic clk = 0, rst_n = 0, start = 0, woffs = 0, clr = 0, din_av = 0, dout_re = 1;
  logic [21:0] wlen = '0;
  logic [31:0] din = '0;
  logic busy, done, din_re, dout_vld, last;
  logic [31:0] dout;
  logic [1:0] dm;
  ahci_dma_wr_align #(.LEN_W(22)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .woffs(woffs), .wlen(wlen), .clr(clr),
    .busy(busy), .done(done), .din(din), .din_av(din_av), .din_re(din_re),
    .dout(dout), .dm(dm), .dout_vld(dout_vld), .dout_re(dout_re), .last(last)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [31:0] d; logic [1:0] m; logic l;} exp_t;
  exp_t exp_q[$];
  logic [31:0] src_q[$];
  int vectors = 0, miscompares = 0, done_cnt = 0, n_done = 0, re_cnt = 0;
  logic stalled_prev = 0;
  logic [31:0] prev_dout = '0;
  logic [2:0] prev_ml = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  always @(posedge clk) begin
    logic pop;
    pop = din_re;
    #1;
    if (pop && src_q.size() > 0) begin
      void'(src_q.pop_front());
      re_cnt++;
    end
    din_av = src_q.size() > 0;
    din = din_av ? src_q[0] : '0;
  end
  always @(negedge clk) begin
    if (!rst_n) stalled_prev = 0;
    else begin
      if (dout_vld && dout_re) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_dword: got %h dm %b, none expected", dout, dm);
        end else begin
          exp_t e;
          logic [31:0] mask;
          e = exp_q.pop_front();
          mask = {{16{e.m[1]}}, {16{e.m[0]}}};
          chk("dout", dout & mask, e.d & mask);
          chk("dm", 32'(dm), 32'(e.m));
          chk("last", 32'(last), 32'(e.l));
        end
      end
      if (dout_vld && !dout_re) begin
        chk("stall_din_re", 32'(din_re), 32'd0);
        if (stalled_prev) begin
          chk("stall_dout", dout, prev_dout);
          chk("stall_dm_last", 32'({dm, last}), 32'(prev_ml));
        end
      end
      stalled_prev = dout_vld && !dout_re;
      prev_dout = dout;
      prev_ml = {dm, last};
      if (done) done_cnt++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic src(input logic [31:0] d);
    src_q.push_back(d);
  endtask
  task automatic expect_dw(input logic [31:0] d, input logic [1:0] m, input logic l);
    exp_q.push_back({d, m, l});
  endtask
  task automatic go(input logic wo, input logic [21:0] wl);
    woffs = wo;
    wlen = wl;
    start = 1;
    tick();
    start = 0;
    n_done++;
  endtask
  task automatic finish_seg(input string name);
    int t;
    t = 0;
    while (done_cnt < n_done && t < 300) begin
      tick();
      t++;
    end
    chk({name, "_done"}, 32'(done_cnt), 32'(n_done));
    chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_src_used"}, 32'(src_q.size()), 32'd0);
    tick();
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask
  task automatic wait_vld(input string name);
    int t;
    t = 0;
    while (!dout_vld && t < 50) begin
      tick();
      t++;
    end
    chk(name, 32'(dout_vld), 32'd1);
  endtask
  initial begin
    int r0;
    repeat (3) tick();
    chk("rst_vld", 32'(dout_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_dm", 32'(dm), 32'd0);
    rst_n = 1;
    tick();
    src(32'h2222_1111); src(32'h4444_3333);
    expect_dw(32'h2222_1111, 2'b11, 0); expect_dw(32'h4444_3333, 2'b11, 1);
    go(0, 4);
    finish_seg("s1");
    r0 = re_cnt;
    src(32'h2222_1111); src(32'h4444_3333);
    expect_dw(32'h1111_0000, 2'b10, 0); expect_dw(32'h3333_2222, 2'b11, 0); expect_dw(32'h0000_4444, 2'b01, 1);
    go(1, 4);
    woffs = 0; wlen = 6; start = 1;
    tick();
    start = 0;
    finish_seg("s2");
    chk("s2_din_re_count", 32'(re_cnt - r0), 32'd2);
    src(32'h2222_1111); src(32'h4444_3333);
    expect_dw(32'h2222_1111, 2'b11, 0); expect_dw(32'h0000_3333, 2'b01, 1);
    go(0, 3);
    finish_seg("carry_a");
    src(32'h6666_5555);
    expect_dw(32'h5555_4444, 2'b11, 1);
    go(0, 2);
    finish_seg("carry_b");
    clr = 1;
    tick();
    clr = 0;
    src(32'hBBBB_AAAA);
    expect_dw(32'hBBBB_AAAA, 2'b11, 1);
    go(0, 2);
    finish_seg("clr");
    go(0, 0);
    @(negedge clk);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_vld", 32'(dout_vld), 32'd0);
    chk("len0_busy", 32'(busy), 32'd0);
    tick(); tick();
    chk("len0_done_once", 32'(done_cnt), 32'(n_done));
    src(32'h0202_0101); src(32'h0404_0303); src(32'h0606_0505); src(32'h0808_0707);
    expect_dw(32'h0202_0101, 2'b11, 0); expect_dw(32'h0404_0303, 2'b11, 0);
    expect_dw(32'h0606_0505, 2'b11, 0); expect_dw(32'h0808_0707, 2'b11, 1);
    dout_re = 0;
    go(0, 8);
    wait_vld("bp_vld");
    repeat (5) tick();
    dout_re = 1;
    finish_seg("bp");
    src(32'h2222_1111); src(32'h4444_3333); src(32'h6666_5555);
    dout_re = 0;
    go(1, 8);
    wait_vld("rst_mid_vld");
    tick();
    #1 rst_n = 0;
    #1;
    chk("arst_vld", 32'(dout_vld), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_last", 32'(last), 32'd0);
    exp_q.delete();
    src_q.delete();
    n_done--;
    tick(); tick();
    dout_re = 1;
    rst_n = 1;
    tick(); tick();
    chk("arst_no_done", 32'(done_cnt), 32'(n_done));
    chk("arst_vld_after", 32'(dout_vld), 32'd0);
    src(32'h2222_1111); src(32'h4444_3333);
    expect_dw(32'h2222_1111, 2'b11, 0); expect_dw(32'h4444_3333, 2'b11, 1);
    go(0, 4);
    finish_seg("post_rst");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
